// File: rtl/goomba_pkg.sv
// Shared types for the goomba spawn controller.
// State encoding, spawn-table entry layout, end marker and a popcount helper.
package goomba_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_CHECK,
        ST_SPAWN,
        ST_WAIT,
        ST_WAIT_FRAME,
        ST_DONE
    } ctrl_state_t;

    localparam logic [7:0] END_COL = 8'hFF;

    typedef struct packed {
        logic [7:0] col;
        logic [3:0] row;
    } spawn_entry_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/goomba_slot_alloc.sv
// Free-slot picker: lowest-index slot whose isAlive bit is clear.
// Ports: alive (per-slot alive), free (any slot free), slot_onehot (chosen slot).
module goomba_slot_alloc #(
    parameter int N = 4
) (
    input  logic [N-1:0] alive,
    output logic         free,
    output logic [N-1:0] slot_onehot
);

    logic [N-1:0] free_vec;

    // x & -x isolates the lowest set bit.
    always_comb begin
        free_vec    = ~alive;
        free        = |free_vec;
        slot_onehot = free_vec & (~free_vec + N'(1));
    end

endmodule

// File: rtl/goomba_spawn_ctrl.sv
// Goomba spawn sequencer: walks the level spawn table, tracks scroll column,
// allocates free goomba slots and issues start/kill pulses with spawn coordinates.
// Ports: Clk/Reset_n, frame_clk/Shift (scroll), level_start/level_restart,
// rom_addr/rom_data (table), isAlive/kill_Mario_in (per slot),
// start/kill/spawnX/spawnY (to slots), world_col, mario_hit, alive_count.
module goomba_spawn_ctrl
    import goomba_pkg::*;
#(
    parameter int N_GOOMBA  = 4,
    parameter int TABLE_AW  = 5,
    parameter int VIEW_COLS = 10,
    parameter int TILE_PX   = 40,
    parameter int SCREEN_X0 = 120,
    parameter int SCREEN_Y0 = 40
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_clk,
    input  logic                Shift,
    input  logic                level_start,
    input  logic                level_restart,
    output logic [TABLE_AW-1:0] rom_addr,
    input  logic [11:0]         rom_data,
    input  logic [N_GOOMBA-1:0] isAlive,
    input  logic [N_GOOMBA-1:0] kill_Mario_in,
    output logic [N_GOOMBA-1:0] start,
    output logic [N_GOOMBA-1:0] kill,
    output logic [9:0]          spawnX,
    output logic [9:0]          spawnY,
    output logic [7:0]          world_col,
    output logic                mario_hit,
    output logic [3:0]          alive_count
);

    ctrl_state_t state, state_n;

    logic [TABLE_AW-1:0] ptr, ptr_n;
    spawn_entry_t        entry;
    logic [N_GOOMBA-1:0] alive_q;
    logic [N_GOOMBA-1:0] slot_oh_q;
    logic [N_GOOMBA-1:0] kill_q;
    logic [9:0]          x_q, y_q;

    logic [1:0] fsync;
    logic       fprev;
    logic       frame_edge;

    logic                free;
    logic [N_GOOMBA-1:0] slot_onehot;

    logic       ptr_last;
    logic       in_view;
    logic       spawning;
    logic [7:0] col_diff;

    goomba_slot_alloc #(
        .N (N_GOOMBA)
    ) u_alloc (
        .alive       (alive_q),
        .free        (free),
        .slot_onehot (slot_onehot)
    );

    // frame_clk is from another domain: two sync flops, then rising edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsync <= '0;
            fprev <= 1'b0;
        end else begin
            fsync <= {fsync[0], frame_clk};
            fprev <= fsync[1];
        end
    end

    assign frame_edge = fsync[1] & ~fprev;

    assign ptr_last = (ptr == {TABLE_AW{1'b1}});
    assign col_diff = entry.col - world_col;

    // 9-bit compare so a view window past column 255 does not wrap.
    assign in_view = ({1'b0, entry.col} <=
                      ({1'b0, world_col} + 9'(VIEW_COLS)));

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        if (level_restart) begin
            state_n = ST_IDLE;
            ptr_n   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (level_start) begin
                        state_n = ST_FETCH;
                        ptr_n   = '0;
                    end
                end
                ST_FETCH: state_n = ST_LATCH;
                ST_LATCH: state_n = ST_CHECK;
                ST_CHECK: begin
                    if (entry.col == END_COL) begin
                        state_n = ST_DONE;
                    end else if (entry.col < world_col) begin
                        // scrolled past: drop it and fetch the next one
                        if (ptr_last) begin
                            state_n = ST_DONE;
                        end else begin
                            ptr_n   = ptr + TABLE_AW'(1);
                            state_n = ST_FETCH;
                        end
                    end else if (in_view && free) begin
                        state_n = ST_SPAWN;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end
                ST_SPAWN: begin
                    if (ptr_last) begin
                        state_n = ST_DONE;
                    end else begin
                        ptr_n   = ptr + TABLE_AW'(1);
                        state_n = ST_WAIT_FRAME;
                    end
                end
                ST_WAIT: begin
                    if (frame_edge) state_n = ST_CHECK;
                end
                ST_WAIT_FRAME: begin
                    if (frame_edge) state_n = ST_FETCH;
                end
                ST_DONE: state_n = ST_DONE;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            entry     <= '0;
            alive_q   <= '0;
            slot_oh_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            alive_q <= isAlive;
            if (level_restart) begin
                entry     <= '0;
                slot_oh_q <= '0;
                x_q       <= '0;
                y_q       <= '0;
            end else begin
                if (state == ST_LATCH) begin
                    entry <= spawn_entry_t'(rom_data);
                end
                // slot and coordinates frozen in CHECK, used in SPAWN
                if (state == ST_CHECK) begin
                    slot_oh_q <= slot_onehot;
                    x_q <= 10'(SCREEN_X0 + int'(col_diff) * TILE_PX
                               + TILE_PX / 2);
                    y_q <= 10'(SCREEN_Y0
                               + (int'(entry.row) + 1) * TILE_PX);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            world_col <= '0;
        end else if (level_restart) begin
            world_col <= '0;
        end else if (frame_edge && Shift && (world_col != 8'hFF)) begin
            world_col <= world_col + 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mario_hit <= 1'b0;
            kill_q    <= '0;
        end else begin
            kill_q <= level_restart ? '1 : '0;
            if (level_restart) begin
                mario_hit <= 1'b0;
            end else begin
                mario_hit <= mario_hit | (|(kill_Mario_in & isAlive));
            end
        end
    end

    // a restart arriving during SPAWN suppresses that start pulse
    assign spawning = (state == ST_SPAWN) && !level_restart;

    assign start    = spawning ? (slot_oh_q & ~kill_q) : '0;
    assign spawnX   = spawning ? x_q : '0;
    assign spawnY   = spawning ? y_q : '0;
    assign kill     = kill_q;
    assign rom_addr = ptr;

    assign alive_count = popcount8(8'(isAlive));

endmodule
